// File: rtl/mem_access_unit.sv
// M-stage data-memory master: issues the M-stage load/store on the req/addr_ok/data_ok bus,
// holds the pipeline while the access is in flight and aligns/extends returned load data.
module mem_access_unit #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memen_i,
    input  logic [2:0]    memop_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          flush_i,
    input  logic          stall_ext_i,
    output logic          stall_o,
    output logic          adel_o,
    output logic          ades_o,
    output logic [DW-1:0] readdata_o,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [DW-1:0] data_wdata,
    output logic [3:0]    data_wstrb,
    input  logic          data_addr_ok,
    input  logic [DW-1:0] data_rdata,
    input  logic          data_data_ok
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic [1:0] op_size(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b101: op_size = 2'd0;
            3'b010, 3'b011, 3'b110: op_size = 2'd1;
            default:                op_size = 2'd2;
        endcase
    endfunction

    function automatic logic op_misalign(input logic [2:0] op, input logic [1:0] a);
        case (op_size(op))
            2'd1:    op_misalign = a[0];
            2'd2:    op_misalign = |a;
            default: op_misalign = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_strb(input logic [2:0] op, input logic [1:0] a);
        case (op)
            3'b101:  lane_strb = 4'b0001 << a;
            3'b110:  lane_strb = a[1] ? 4'b1100 : 4'b0011;
            3'b111:  lane_strb = 4'b1111;
            default: lane_strb = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] op, input logic [31:0] d);
        case (op)
            3'b101:  lane_wdata = {4{d[7:0]}};
            3'b110:  lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] load_align(input logic [2:0] op, input logic [1:0] a,
                                               input logic [31:0] d);
        logic [31:0] sh;
        logic [15:0] h;
        sh = d >> {a, 3'b000};
        h  = a[1] ? d[31:16] : d[15:0];
        case (op)
            3'b000:  load_align = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_align = {24'd0, sh[7:0]};
            3'b010:  load_align = {{16{h[15]}}, h};
            3'b011:  load_align = {16'd0, h};
            default: load_align = d;
        endcase
    endfunction

    state_e        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic          wr_q, wr_d;
    logic [1:0]    size_q, size_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    strb_q, strb_d;
    logic          discard_q, discard_d;
    logic [DW-1:0] readdata_q, readdata_d;

    logic          load_s, misalign_s, start_s, discard_s;

    // Alignment checks, exception flags and issue decision for the current M-stage op
    always_comb begin
        load_s     = (memop_i <= 3'd4);
        misalign_s = op_misalign(memop_i, addr_i[1:0]);
        adel_o     = memen_i & load_s & misalign_s;
        ades_o     = memen_i & ~load_s & misalign_s;
        start_s    = (state_q == IDLE) & memen_i & ~misalign_s & ~flush_i;
    end

    // Transaction sequencing and next-state values for all registered fields
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wr_d       = wr_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        discard_d  = discard_q;
        readdata_d = readdata_q;
        discard_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d   = ADDR;
                    op_d      = memop_i;
                    wr_d      = ~load_s;
                    size_d    = op_size(memop_i);
                    addr_d    = addr_i;
                    wdata_d   = lane_wdata(memop_i, wdata_i);
                    strb_d    = lane_strb(memop_i, addr_i[1:0]);
                    discard_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                // Once accepted the response must still be drained, so a flush only marks it
                if (data_addr_ok) begin
                    state_d   = DATA;
                    discard_d = flush_i;
                end else if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = ADDR;
                end
            end
            DATA: begin
                discard_s = discard_q | flush_i;
                if (data_data_ok) begin
                    if (~discard_s & ~wr_q) begin
                        readdata_d = load_align(op_q, addr_q[1:0], data_rdata);
                    end else begin
                        readdata_d = readdata_q;
                    end
                    state_d   = discard_s ? IDLE : DONE;
                    discard_d = 1'b0;
                end else begin
                    discard_d = discard_s;
                end
            end
            DONE: begin
                state_d = stall_ext_i ? DONE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and bus-field registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 3'd0;
            wr_q       <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= 4'd0;
            discard_q  <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            discard_q  <= discard_d;
            readdata_q <= readdata_d;
        end
    end

    assign data_req   = (state_q == ADDR);
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign data_wstrb = strb_q;
    assign readdata_o = readdata_q;
    assign stall_o    = ~rst & (start_s | (state_q == ADDR) | (state_q == DATA));

endmodule
